// File: rtl/uart_rx_voter.sv
// uart_rx_voter
//   Oversampling UART receiver with per-bit majority voting.
//   The line is synchronised through two flops. Each frame bit (start, data,
//   optional even parity, stop) is sampled for SPB clocks and resolved by
//   majority. Results are registered one clock after stop resolution.
//
// Parameters
//   BIT_LEN   : data bits per frame (>= 2)
//   SPB       : clocks per bit, odd, >= 1 (1 = no voting)
//   PARITY_EN : 1 = even parity bit follows the data, 0 = no parity bit
//
// Ports
//   clk           : clock, all state changes on the rising edge
//   rst           : asynchronous active-high reset
//   rx_channel_in : serial line, idle high
//   rx_data_out   : last correctly received word
//   rx_out_valid  : one-cycle pulse when rx_data_out updates
//   parity_err    : one-cycle pulse on a parity mismatch
//   frame_err     : one-cycle pulse when the stop bit votes 0
//   rx_busy       : high whenever the receiver FSM is not idle
module uart_rx_voter #(
  parameter int BIT_LEN   = 7,
  parameter int SPB       = 3,
  parameter int PARITY_EN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_channel_in,
  output logic [BIT_LEN-1:0] rx_data_out,
  output logic               rx_out_valid,
  output logic               parity_err,
  output logic               frame_err,
  output logic               rx_busy
);

  localparam int CW = $clog2(SPB + 1);
  localparam int BW = $clog2(BIT_LEN + 1);
  localparam logic [CW-1:0] SMP_LAST = CW'(SPB - 1);
  localparam logic [CW-1:0] HALF     = CW'(SPB / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_LEN - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even-parity reduction of a data word.
  function automatic logic even_parity(input logic [BIT_LEN-1:0] w);
    return ^w;
  endfunction

  logic               sync1_q, sync2_q;
  state_t             state_q, state_d;
  logic               arm_q, arm_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      ones_q, ones_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [BIT_LEN-1:0] shift_q, shift_d;
  logic               perr_q, perr_d;
  logic               fin_q, fin_d;
  logic               fin_stop_q, fin_stop_d;
  logic [BIT_LEN-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               perr_out_q, perr_out_d;
  logic               ferr_q, ferr_d;
  logic               busy_q, busy_d;

  logic               s;
  logic [CW-1:0]      ones_now;
  logic               vote;
  logic               last_smp;

  assign s        = sync2_q;
  // Ones seen in this bit including the current sample.
  assign ones_now = ones_q + CW'(s);
  assign vote     = (ones_now > HALF);
  assign last_smp = (cnt_q == SMP_LAST);

  // Next-state logic for the receiver FSM and its datapath.
  always_comb begin
    state_d    = state_q;
    arm_d      = arm_q;
    cnt_d      = cnt_q;
    ones_d     = ones_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    fin_d      = 1'b0;
    fin_stop_d = fin_stop_q;

    // Sample bookkeeping shared by every non-idle state.
    if (state_q != IDLE) begin
      if (last_smp) begin
        cnt_d  = {CW{1'b0}};
        ones_d = {CW{1'b0}};
      end else begin
        cnt_d  = cnt_q + CW'(1);
        ones_d = ones_now;
      end
    end else begin
      cnt_d  = cnt_q;
      ones_d = ones_q;
    end

    case (state_q)
      IDLE: begin
        if (!arm_q) begin
          // After a frame error, wait for the line to go high again.
          arm_d = s;
        end else if (!s) begin
          // The entry sample is the first start-bit sample (it is a 0).
          perr_d = 1'b0;
          bit_d  = {BW{1'b0}};
          if (SPB == 1) begin
            state_d = DATA;
            cnt_d   = {CW{1'b0}};
            ones_d  = {CW{1'b0}};
          end else begin
            state_d = START;
            cnt_d   = CW'(1);
            ones_d  = {CW{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (last_smp) begin
          if (vote) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (last_smp) begin
          shift_d = {vote, shift_q[BIT_LEN-1:1]};
          bit_d   = bit_q + BW'(1);
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (last_smp) begin
          perr_d  = even_parity(shift_q) ^ vote;
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (last_smp) begin
          state_d    = IDLE;
          fin_d      = 1'b1;
          fin_stop_d = vote;
          if (!vote) begin
            arm_d = 1'b0;
          end else begin
            arm_d = arm_q;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode, taking effect one clock after stop resolution.
  always_comb begin
    valid_d    = fin_q & fin_stop_q & ~perr_q;
    perr_out_d = fin_q & perr_q;
    ferr_d     = fin_q & ~fin_stop_q;
    busy_d     = (state_d != IDLE);
    if (valid_d) begin
      data_d = shift_q;
    end else begin
      data_d = data_q;
    end
  end

  // State, synchroniser and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= IDLE;
      arm_q      <= 1'b1;
      cnt_q      <= {CW{1'b0}};
      ones_q     <= {CW{1'b0}};
      bit_q      <= {BW{1'b0}};
      shift_q    <= {BIT_LEN{1'b0}};
      perr_q     <= 1'b0;
      fin_q      <= 1'b0;
      fin_stop_q <= 1'b0;
      data_q     <= {BIT_LEN{1'b0}};
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= rx_channel_in;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      arm_q      <= arm_d;
      cnt_q      <= cnt_d;
      ones_q     <= ones_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      fin_q      <= fin_d;
      fin_stop_q <= fin_stop_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data_out  = data_q;
  assign rx_out_valid = valid_q;
  assign parity_err   = perr_out_q;
  assign frame_err    = ferr_q;
  assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_voter.sv
// Testbench for uart_rx_voter: directed frames plus randomized frames,
// checked against a frame-level reference (expected pulse kind, time and data).
module tb_uart_rx_voter;

  localparam int BIT_LEN = 7;
  localparam int SPB     = 3;
  localparam int LAT     = 2 + (BIT_LEN + 3) * SPB;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               rx  = 1'b1;
  logic [BIT_LEN-1:0] rx_data_out;
  logic               rx_out_valid;
  logic               parity_err;
  logic               frame_err;
  logic               rx_busy;

  uart_rx_voter #(.BIT_LEN(BIT_LEN), .SPB(SPB), .PARITY_EN(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_channel_in(rx),
    .rx_data_out  (rx_data_out),
    .rx_out_valid (rx_out_valid),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  // Rising-edge counter used to time-stamp pulses.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int n_val, n_perr, n_ferr, n_busy;
  int c_val, c_perr, c_ferr;
  int drv_edge;
  logic [BIT_LEN-1:0] exp_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    n_val = 0; n_perr = 0; n_ferr = 0; n_busy = 0;
    c_val = -1; c_perr = -1; c_ferr = -1;
  endtask

  // One clock: observe outputs of the previous edge, then drive the next pin sample.
  task automatic step(input logic v);
    @(negedge clk);
    if (rx_out_valid) begin n_val++;  c_val  = cyc; end
    if (parity_err)   begin n_perr++; c_perr = cyc; end
    if (frame_err)    begin n_ferr++; c_ferr = cyc; end
    if (rx_busy)      n_busy++;
    rx = v;
    drv_edge = cyc + 1;
  endtask

  // Drive one full frame; optionally invert one sample per bit.
  task automatic send_frame(input logic [BIT_LEN-1:0] d, input logic par_flip,
                            input logic stop_bit, input logic noisy, output int t);
    logic [BIT_LEN+2:0] bits;
    bits = {stop_bit, (^d) ^ par_flip, d, 1'b0};
    t = 0;
    for (int b = 0; b < BIT_LEN + 3; b++) begin
      int np;
      // Start bit keeps its first sample clean so frame timing is defined.
      np = (b == 0) ? int'($urandom_range(SPB - 1, 1)) : int'($urandom_range(SPB - 1, 0));
      for (int k = 0; k < SPB; k++) begin
        step(bits[b] ^ (noisy && (k == np)));
        if (b == 0 && k == 0) t = drv_edge;
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [BIT_LEN-1:0] d, input logic par_flip,
                           input logic stop_bit, input logic noisy, input int low_tail);
    int t;
    int nb;
    logic exp_v, exp_p, exp_f;
    clear_mon();
    send_frame(d, par_flip, stop_bit, noisy, t);
    exp_p = par_flip;
    exp_f = ~stop_bit;
    exp_v = stop_bit & ~par_flip;
    if (exp_v) exp_data = d;
    if (low_tail > 0) begin
      while (drv_edge < t + LAT + 2) step(1'b0);
      nb = n_busy;
      repeat (low_tail) step(1'b0);
      chk({tag, "_lowline_busy"}, n_busy - nb, 0);
    end
    while (drv_edge < t + LAT + 8) step(1'b1);
    repeat (4) step(1'b1);
    chk({tag, "_valid_cnt"}, n_val, exp_v);
    chk({tag, "_perr_cnt"}, n_perr, exp_p);
    chk({tag, "_ferr_cnt"}, n_ferr, exp_f);
    if (exp_v) chk({tag, "_valid_time"}, c_val, t + LAT);
    if (exp_p) chk({tag, "_perr_time"}, c_perr, t + LAT);
    if (exp_f) chk({tag, "_ferr_time"}, c_ferr, t + LAT);
    chk({tag, "_data"}, rx_data_out, exp_data);
    chk({tag, "_busy_end"}, rx_busy, 0);
  endtask

  initial begin
    clear_mon();
    drv_edge = 0;
    // Reset state
    repeat (3) step(1'b1);
    chk("rst_data", rx_data_out, 0);
    chk("rst_flags", {rx_out_valid, parity_err, frame_err, rx_busy}, 4'b0000);
    rst = 1'b0;
    repeat (6) step(1'b1);

    // Clean and noisy reference frame
    run_frame("clean", 7'b1010011, 1'b0, 1'b1, 1'b0, 0);
    run_frame("noisy", 7'b1010011, 1'b0, 1'b1, 1'b1, 0);

    // Single-sample glitch on an idle line
    clear_mon();
    step(1'b0);
    repeat (10) step(1'b1);
    chk("glitch_pulses", n_val + n_perr + n_ferr, 0);
    chk("glitch_busy_le3", (n_busy >= 1 && n_busy <= 3), 1);

    // Parity error keeps the previous word
    run_frame("pre_par", 7'b0011100, 1'b0, 1'b1, 1'b0, 0);
    run_frame("par_err", 7'b1010011, 1'b1, 1'b1, 1'b0, 0);

    // Frame error with the line held low, then a clean frame
    run_frame("frm_err", 7'b1100101, 1'b0, 1'b0, 1'b0, 15);
    run_frame("after_frm", 7'b0101100, 1'b0, 1'b1, 1'b0, 0);

    // Parity and frame error together
    run_frame("both_err", 7'b0110001, 1'b1, 1'b0, 1'b1, 6);

    // Reset in the middle of a frame's data field
    clear_mon();
    repeat (SPB) step(1'b0);
    repeat (4 * SPB + 2) step(1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_data", rx_data_out, 0);
    chk("midrst_flags", {rx_out_valid, parity_err, frame_err, rx_busy}, 4'b0000);
    exp_data = '0;
    step(1'b1);
    step(1'b1);
    rst = 1'b0;
    clear_mon();
    repeat (40) step(1'b1);
    chk("midrst_nopulse", n_val + n_perr + n_ferr, 0);
    run_frame("after_rst", 7'b1111111, 1'b0, 1'b1, 1'b0, 0);

    // Randomized frames
    for (int i = 0; i < 20; i++) begin
      logic [BIT_LEN-1:0] d;
      logic pf, sb, nz;
      int lt;
      d  = BIT_LEN'($urandom);
      pf = ($urandom_range(3, 0) == 0);
      sb = ($urandom_range(5, 0) != 0);
      nz = $urandom_range(1, 0) != 0;
      lt = sb ? 0 : int'($urandom_range(12, 1));
      run_frame("rand", d, pf, sb, nz, lt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
